// File: rtl/spi_reg_sequencer.sv
// SPI byte-stream to register-bank sequencer: command byte, then write or read bursts.
// Strobes one cycle after each rx_valid; read data reaches tx_byte 3 cycles after its trigger; no backpressure.
module spi_reg_sequencer #(
    parameter int NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       addr_err,
    output logic [7:0] xfer_count
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_t;

    localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t     state_q;
    logic       armed_q;
    logic       cap_q;
    logic [6:0] addr_q;
    logic [6:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic [7:0] tx_byte_q;
    logic       addr_err_q;
    logic [7:0] xfer_count_q;

    logic [6:0] cmd_addr;
    logic       cmd_bad;
    logic [6:0] cmd_addr_inc;
    logic [6:0] addr_inc;
    logic [7:0] count_inc;

    function automatic logic [6:0] wrap_inc(input logic [6:0] a);
        return (a == LAST_ADDR) ? 7'd0 : a + 7'd1;
    endfunction

    assign cmd_addr     = rx_byte[6:0];
    assign cmd_bad      = ({1'b0, cmd_addr} >= NUM_REGS_B);
    assign cmd_addr_inc = wrap_inc(cmd_addr);
    assign addr_inc     = wrap_inc(addr_q);
    assign count_inc    = (xfer_count_q == 8'hFF) ? 8'hFF : xfer_count_q + 8'd1;

    // armed_q blocks a command until cs_n has been seen high since reset,
    // so a transaction cut by reset is never resumed mid-stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            cap_q        <= 1'b0;
            addr_q       <= 7'd0;
            reg_addr_q   <= 7'd0;
            reg_wdata_q  <= 8'h00;
            reg_we_q     <= 1'b0;
            reg_re_q     <= 1'b0;
            tx_byte_q    <= 8'h00;
            addr_err_q   <= 1'b0;
            xfer_count_q <= 8'h00;
        end else begin
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            addr_err_q <= 1'b0;
            cap_q      <= 1'b0;
            if (cs_n) begin
                armed_q <= 1'b1;
                if (state_q != IDLE) begin
                    state_q   <= IDLE;
                    tx_byte_q <= 8'h00;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (armed_q) begin
                            state_q      <= CMD;
                            xfer_count_q <= 8'h00;
                        end
                    end
                    CMD: begin
                        if (rx_valid) begin
                            if (cmd_bad) begin
                                state_q    <= DISCARD;
                                addr_err_q <= 1'b1;
                                tx_byte_q  <= 8'hFF;
                            end else if (rx_byte[7]) begin
                                state_q    <= WRITE;
                                reg_addr_q <= cmd_addr;
                                addr_q     <= cmd_addr;
                            end else begin
                                state_q    <= READ;
                                reg_re_q   <= 1'b1;
                                reg_addr_q <= cmd_addr;
                                addr_q     <= cmd_addr_inc;
                            end
                        end
                    end
                    WRITE: begin
                        if (rx_valid) begin
                            reg_we_q     <= 1'b1;
                            reg_wdata_q  <= rx_byte;
                            reg_addr_q   <= addr_q;
                            addr_q       <= addr_inc;
                            xfer_count_q <= count_inc;
                        end
                    end
                    READ: begin
                        // reg_rdata is valid the cycle after reg_re; capture then.
                        cap_q <= reg_re_q;
                        if (cap_q) begin
                            tx_byte_q <= reg_rdata;
                        end
                        if (rx_valid) begin
                            reg_re_q     <= 1'b1;
                            reg_addr_q   <= addr_q;
                            addr_q       <= addr_inc;
                            xfer_count_q <= count_inc;
                        end
                    end
                    DISCARD: begin
                        if (rx_valid) begin
                            xfer_count_q <= count_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_byte    = tx_byte_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_we     = reg_we_q;
    assign reg_re     = reg_re_q;
    assign addr_err   = addr_err_q;
    assign xfer_count = xfer_count_q;

endmodule
